// File: rtl/gf_mult_arbiter.sv
// gf_mult_arbiter: round-robin sharing of one GF(2^163) interleaved multiplier
// among NREQ requesters. Latches the winner's operands, holds mult_start for
// the whole operation, returns the product with a one-cycle ack and pulses the
// multiplier reset so it can accept the next operation. A watchdog aborts an
// operation that never signals done.
//
// state | meaning
// ------+--------------------------------------------------------------------
// IDLE  | no operation; grants once the multiplier reset has been released
// RUN   | multiplier running on latched operands; watchdog counting down
// CLR   | ack and response presented; multiplier held in reset for one cycle
module gf_mult_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int M       = 163,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*M-1:0] req_a,
    input  logic [NREQ*M-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [M-1:0]      rsp_z,
    output logic              rsp_err,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic [M-1:0]      mult_a,
    output logic [M-1:0]      mult_b,
    output logic              mult_start,
    output logic              mult_rst,
    input  logic [M-1:0]      mult_z,
    input  logic              mult_done
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [IDW-1:0]  ptr, ptr_d;
    logic [WDW-1:0]  wd, wd_d;
    logic [NREQ-1:0] ack_d;
    logic [M-1:0]    rsp_z_d;
    logic            rsp_err_d;
    logic [IDW-1:0]  grant_id_d;
    logic [M-1:0]    mult_a_d;
    logic [M-1:0]    mult_b_d;
    logic            mult_start_d;
    logic            mult_rst_d;
    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;

    assign busy = (state != IDLE);

    // Rotating-priority search: the lowest offset from the pointer wins,
    // so iterate from the farthest candidate and let nearer ones overwrite.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        wd_d         = wd;
        ack_d        = '0;
        rsp_z_d      = rsp_z;
        rsp_err_d    = rsp_err;
        grant_id_d   = grant_id;
        mult_a_d     = mult_a;
        mult_b_d     = mult_b;
        mult_start_d = 1'b0;
        mult_rst_d   = 1'b0;
        case (state)
            IDLE: begin
                // mult_rst still high right after reset: let the multiplier
                // see one released cycle before it is started.
                if (pick_vld && !mult_rst && !mult_start) begin
                    mult_a_d     = req_a[pick_id * M +: M];
                    mult_b_d     = req_b[pick_id * M +: M];
                    grant_id_d   = pick_id;
                    mult_start_d = 1'b1;
                    wd_d         = WDW'(TIMEOUT);
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (mult_done) begin
                    rsp_z_d          = mult_z;
                    rsp_err_d        = 1'b0;
                    ack_d[grant_id]  = 1'b1;
                    mult_rst_d       = 1'b1;
                    state_d          = CLR;
                end else if (wd == '0) begin
                    rsp_z_d          = '0;
                    rsp_err_d        = 1'b1;
                    ack_d[grant_id]  = 1'b1;
                    mult_rst_d       = 1'b1;
                    state_d          = CLR;
                end else begin
                    mult_start_d = 1'b1;
                    wd_d         = wd - 1'b1;
                end
            end
            CLR: begin
                ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            wd         <= '0;
            ack        <= '0;
            rsp_z      <= '0;
            rsp_err    <= 1'b0;
            grant_id   <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_start <= 1'b0;
            mult_rst   <= 1'b1;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            wd         <= wd_d;
            ack        <= ack_d;
            rsp_z      <= rsp_z_d;
            rsp_err    <= rsp_err_d;
            grant_id   <= grant_id_d;
            mult_a     <= mult_a_d;
            mult_b     <= mult_b_d;
            mult_start <= mult_start_d;
            mult_rst   <= mult_rst_d;
        end
    end

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Testbench for gf_mult_arbiter with a behavioural multiplier stub.
module tb_gf_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int M       = 163;
    localparam int TIMEOUT = 255;
    localparam int IDW     = 2;
    localparam int LAT     = 167;
    localparam int LIMIT   = 2000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] req_a, req_b;
    logic [NREQ-1:0]   ack;
    logic [M-1:0]      rsp_z;
    logic              rsp_err, busy;
    logic [IDW-1:0]    grant_id;
    logic [M-1:0]      mult_a, mult_b;
    logic              mult_start, mult_rst;
    logic [M-1:0]      mult_z = '0;
    logic              mult_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic start_q = 1'b0;
    logic stub_en = 1'b1;
    int ref_ptr = 0;
    int scnt = 0;
    logic sfin = 1'b0;
    logic [M-1:0] opa[NREQ];
    logic [M-1:0] opb[NREQ];

    typedef struct {
        int           id;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] z;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    gf_mult_arbiter #(.NREQ(NREQ), .M(M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy),
        .grant_id(grant_id), .mult_a(mult_a), .mult_b(mult_b),
        .mult_start(mult_start), .mult_rst(mult_rst),
        .mult_z(mult_z), .mult_done(mult_done)
    );

    // GF(2^163) product modulo x^163 + x^7 + x^6 + x^3 + 1.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [2*M-2:0] poly;
        p = '0;
        poly = '0;
        poly[M] = 1'b1; poly[7] = 1'b1; poly[6] = 1'b1; poly[3] = 1'b1; poly[0] = 1'b1;
        for (int i = 0; i < M; i++)
            if (b[i]) p = p ^ ((2*M-1)'(a) << i);
        for (int i = 2*M-2; i >= M; i--)
            if (p[i]) p = p ^ (poly << (i - M));
        return p[M-1:0];
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [M-1:0] rand_op();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[M-1:0];
    endfunction

    // Multiplier stub: done LAT cycles after start, sticky until reset.
    always @(posedge clk) begin
        if (mult_rst) begin
            scnt <= 0; sfin <= 1'b0; mult_done <= 1'b0; mult_z <= '0;
        end else if (mult_start && !sfin) begin
            if (scnt == LAT - 1) begin
                if (stub_en) begin
                    mult_done <= 1'b1; mult_z <= gf_mul(mult_a, mult_b); sfin <= 1'b1;
                end
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of each mult_start rising edge.
    always @(negedge clk) begin
        if (mult_start && !start_q) start_cyc = cyc;
        start_q = mult_start;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*M +: M] = b;
        opa[i] = a;
        opb[i] = b;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"}, M'(ack), '0);
        chk({tag, "_rsp_z"}, rsp_z, '0);
        chk({tag, "_rsp_err"}, M'(rsp_err), '0);
        chk({tag, "_grant_id"}, M'(grant_id), '0);
        chk({tag, "_mult_a"}, mult_a, '0);
        chk({tag, "_mult_b"}, mult_b, '0);
        chk({tag, "_mult_start"}, M'(mult_start), '0);
        chk({tag, "_mult_rst"}, M'(mult_rst), M'(1));
        chk({tag, "_busy"}, M'(busy), '0);
    endtask

    task automatic wait_idle();
        bool_loop: for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (!busy && !mult_rst) return;
        end
        chk("idle_timeout", M'(busy), '0);
    endtask

    // Wait for the next ack; drop that requester's req unless hold is set.
    task automatic wait_ack(input bit hold, output int id, output logic [M-1:0] z,
                            output logic e, output int acyc, output int nrst);
        bit got;
        got = 1'b0; id = -1; z = '0; e = 1'b0; acyc = 0; nrst = 0;
        for (int n = 0; n < LIMIT && !got; n++) begin
            @(negedge clk);
            if (mult_rst) nrst++;
            if (ack != '0) begin
                got = 1'b1;
                acyc = cyc; z = rsp_z; e = rsp_err;
                for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
                chk("ack_onehot", M'($onehot(ack)), M'(1));
                chk("mult_rst_with_ack", M'(mult_rst), M'(1));
                if (!hold && id >= 0) req[id] = 1'b0;
            end
        end
        if (!got) chk("ack_timeout", '0, M'(1));
    endtask

    // Serve nacks acks from the given request set, checking against the model.
    task automatic serve(input logic [NREQ-1:0] mask, input bit hold, input int nacks, input string tag);
        logic [NREQ-1:0] pend;
        int id, ac, nr, exp_id, prev_ac;
        logic [M-1:0] z;
        logic e;
        pend = mask;
        prev_ac = 0;
        for (int j = 0; j < nacks; j++) begin
            exp_id = rr_pick(pend, ref_ptr);
            wait_ack(hold, id, z, e, ac, nr);
            chk({tag, "_id"}, M'(id), M'(exp_id));
            chk({tag, "_z"}, z, gf_mul(opa[exp_id], opb[exp_id]));
            chk({tag, "_err"}, M'(e), '0);
            if (j > 0) chk({tag, "_gap"}, M'(start_cyc - prev_ac), M'(2));
            prev_ac = ac;
            ref_ptr = (exp_id + 1) % NREQ;
            if (!hold) pend[exp_id] = 1'b0;
        end
    endtask

    initial begin
        logic [M-1:0] one, x162, x161, x1, x2, r7631, z;
        logic [NREQ-1:0] mask;
        int id, ac, ac1, nr, rc, nack;
        logic e;

        one = 1;
        x1 = one << 1; x2 = one << 2; x161 = one << 161; x162 = one << 162;
        r7631 = (one << 7) | (one << 6) | (one << 3) | one;
        tbl[0] = '{0, one, x162, x162};
        tbl[1] = '{2, x1, x161, x162};
        tbl[2] = '{3, x2, x161, r7631};
        tbl[3] = '{1, (one << 81) | one, one << 82, (one << 82) | r7631};

        req = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        ref_ptr = 0;

        // Simultaneous requests 1 and 3.
        wait_idle();
        set_op(1, rand_op(), rand_op());
        set_op(3, rand_op(), rand_op());
        req = 4'b1010;
        serve(4'b1010, 1'b0, 2, "simul");

        // Fairness: all four held high.
        wait_idle();
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
        req = 4'b1111;
        serve(4'b1111, 1'b1, 5, "fair");
        req = '0;

        // Directed single-request vectors.
        for (int t = 0; t < 4; t++) begin
            wait_idle();
            set_op(tbl[t].id, tbl[t].a, tbl[t].b);
            req[tbl[t].id] = 1'b1;
            rc = cyc;
            wait_ack(1'b0, id, z, e, ac, nr);
            chk("tbl_id", M'(id), M'(tbl[t].id));
            chk("tbl_z", z, tbl[t].z);
            chk("tbl_err", M'(e), '0);
            chk("tbl_latency", M'(ac - rc), M'(LAT + 2));
            chk("tbl_grant_delay", M'(start_cyc - rc), M'(1));
            chk("tbl_mult_rst_pulses", M'(nr), M'(1));
            ref_ptr = (tbl[t].id + 1) % NREQ;
            repeat (3) @(negedge clk);
            chk("tbl_z_held", rsp_z, tbl[t].z);
        end

        // Watchdog timeout.
        wait_idle();
        stub_en = 1'b0;
        set_op(0, rand_op(), rand_op());
        req[0] = 1'b1;
        wait_ack(1'b0, id, z, e, ac, nr);
        chk("to_id", M'(id), '0);
        chk("to_err", M'(e), M'(1));
        chk("to_z", z, '0);
        chk("to_cycles", M'(ac - start_cyc), M'(TIMEOUT + 1));
        stub_en = 1'b1;
        ref_ptr = 1;

        // Reset at RUN cycle 50.
        wait_idle();
        set_op(0, rand_op(), rand_op());
        req[0] = 1'b1;
        repeat (51) @(negedge clk);
        chk("rst_busy_before", M'(busy), M'(1));
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        check_reset_vals("midrun");
        rst_n = 1'b1;
        ref_ptr = 0;
        nack = 0;
        repeat (300) begin
            @(negedge clk);
            if (ack != '0) nack++;
        end
        chk("rst_no_ack", M'(nack), '0);
        set_op(0, rand_op(), rand_op());
        req[0] = 1'b1;
        serve(4'b0001, 1'b0, 1, "rerequest");

        // Back-to-back on one requester; operand changes after grant ignored.
        wait_idle();
        set_op(0, x1, x161);
        req[0] = 1'b1;
        repeat (5) @(negedge clk);
        req_a[0 +: M] = rand_op();
        req_b[0 +: M] = rand_op();
        wait_ack(1'b0, id, z, e, ac1, nr);
        chk("b2b1_z", z, x162);
        @(negedge clk);
        set_op(0, x2, x161);
        req[0] = 1'b1;
        wait_ack(1'b0, id, z, e, ac, nr);
        chk("b2b2_z", z, r7631);
        chk("b2b2_err", M'(e), '0);
        chk("b2b_gap", M'(start_cyc - ac1), M'(2));
        ref_ptr = 1;

        // Randomized request sets.
        for (int r = 0; r < 15; r++) begin
            wait_idle();
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) if (mask[i]) set_op(i, rand_op(), rand_op());
            req = mask;
            serve(mask, 1'b0, $countones(mask), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
